// File: rtl/ahb_gpio_seq.sv
// ahb_gpio_seq: AHB-Lite master that walks a one-hot pattern through the GPIO
// data register and reads each value back. Transfers are strictly single
// (address phase, then data phase, never overlapped).
module ahb_gpio_seq #(
  parameter int unsigned STEPS    = 16,
  parameter int unsigned INTERVAL = 4,
  parameter logic [15:0] DIR_VAL  = 16'hFFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic        abort,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HSEL,
  output logic        busy,
  output logic        done,
  output logic        mismatch,
  output logic [15:0] rd_data
);

  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;
  localparam logic [31:0] A_DATA    = 32'h0000_0000;
  localparam logic [31:0] A_DIR     = 32'h0000_0004;
  localparam logic [7:0]  IVL       = 8'(INTERVAL);
  localparam logic [16:0] STEPS_W   = 17'(STEPS);

  typedef enum logic [3:0] {
    S_IDLE, S_DIR_A, S_DIR_D, S_WR_A, S_WR_D, S_WAIT, S_RD_A, S_RD_D, S_FIN
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] step;
  logic [7:0]  wait_cnt;
  logic        abort_pend;
  logic        abort_eff;
  logic [16:0] step_inc;
  logic        last_step;
  logic [15:0] pattern;
  logic        unused_bits;

  // an abort seen this cycle acts the same as one already pending
  assign abort_eff   = abort_pend | abort;
  assign step_inc    = {1'b0, step} + 17'd1;
  assign last_step   = (step_inc == STEPS_W);
  // walking one wraps every 16 steps
  assign pattern     = 16'h0001 << step[3:0];
  assign unused_bits = ^{HRDATA[31:16], step_inc[16]};

  // state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state: every presented address phase runs through its data phase
  // before an abort is honoured; WAIT bails out immediately
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)  state_nxt = S_DIR_A;
      S_DIR_A: if (HREADY) state_nxt = S_DIR_D;
      S_DIR_D: if (HREADY) state_nxt = abort_eff ? S_FIN : S_WR_A;
      S_WR_A:  if (HREADY) state_nxt = S_WR_D;
      S_WR_D:  if (HREADY) begin
                 if (abort_eff)      state_nxt = S_FIN;
                 else if (IVL == 0)  state_nxt = S_RD_A;
                 else                state_nxt = S_WAIT;
               end
      S_WAIT:  if (abort_eff)          state_nxt = S_FIN;
               else if (wait_cnt == 8'd1) state_nxt = S_RD_A;
      S_RD_A:  if (HREADY) state_nxt = S_RD_D;
      S_RD_D:  if (HREADY) state_nxt = (abort_eff || last_step) ? S_FIN : S_WR_A;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // sequence bookkeeping: step count, wait timer, abort latch, read-back check
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      step       <= '0;
      wait_cnt   <= '0;
      abort_pend <= 1'b0;
      mismatch   <= 1'b0;
      rd_data    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          step       <= '0;
          mismatch   <= 1'b0;
          abort_pend <= abort;
        end
        S_FIN:   abort_pend <= 1'b0;
        default: if (abort) abort_pend <= 1'b1;
      endcase
      if (state == S_WR_D && HREADY) wait_cnt <= IVL;
      else if (state == S_WAIT)      wait_cnt <= wait_cnt - 8'd1;
      if (state == S_RD_D && HREADY) begin
        rd_data <= HRDATA[15:0];
        if (HRDATA[15:0] != pattern) mismatch <= 1'b1;
        step <= step_inc[15:0];
      end
    end
  end

  // bus and status outputs decoded from state, so reset clears them at once
  always_comb begin
    HADDR  = '0;
    HTRANS = HT_IDLE;
    HWRITE = 1'b0;
    HSEL   = 1'b0;
    HWDATA = '0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_DIR_A: begin HSEL = 1'b1; HTRANS = HT_NONSEQ; HADDR = A_DIR;  HWRITE = 1'b1; end
      S_DIR_D: HWDATA = {16'h0, DIR_VAL};
      S_WR_A:  begin HSEL = 1'b1; HTRANS = HT_NONSEQ; HADDR = A_DATA; HWRITE = 1'b1; end
      S_WR_D:  HWDATA = {16'h0, pattern};
      S_RD_A:  begin HSEL = 1'b1; HTRANS = HT_NONSEQ; HADDR = A_DATA; end
      S_FIN:   begin busy = 1'b0; done = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_gpio_seq.sv
// tb_ahb_gpio_seq: two sequencer instances (long run with idle gap, short run
// with no gap) driven against a GPIO slave model with optional stuck bits and
// random wait states. A transfer-level model predicts every bus transfer.
module tb_ahb_gpio_seq;

  localparam int STEPS0 = 17;
  localparam int IVL0   = 2;
  localparam int STEPS1 = 3;
  localparam int IVL1   = 0;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start  [2];
  logic        abort  [2];
  logic        hready [2];
  logic [31:0] hrdata [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic        hsel   [2];
  logic        busy   [2];
  logic        done   [2];
  logic        mm     [2];
  logic [15:0] rd     [2];

  // slave / model state
  logic [15:0] gpio   [2];
  logic [15:0] stuck  [2];
  bit          rnd    [2];
  int          xfer_cnt [2];
  int          done_cnt [2];
  int          idle_cnt [2];
  bit          in_data [2];
  bit          in_addr [2];
  bit          first   [2];
  bit          cur_write [2];
  bit          a_wr    [2];
  bit          pend_rd [2];
  bit          mm_model [2];
  logic [31:0] cur_addr [2];
  logic [31:0] a_addr  [2];
  logic [31:0] cur_wd  [2];
  logic [15:0] exp_rd  [2];

  int checks;
  int failures;

  typedef struct {
    int          inst;
    logic [15:0] stuck;
    bit          rnd;
    bit          abrt;
    int          exp_xfers;
    bit          exp_mm;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  always #10 HCLK = ~HCLK;

  // GPIO output looped back to input, with optional stuck-at-0 bits
  assign hrdata[0] = {16'h0, gpio[0] & ~stuck[0]};
  assign hrdata[1] = {16'h0, gpio[1] & ~stuck[1]};

  ahb_gpio_seq #(.STEPS(STEPS0), .INTERVAL(IVL0), .DIR_VAL(16'hFFFF)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start[0]), .abort(abort[0]),
    .HREADY(hready[0]), .HRDATA(hrdata[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HWDATA(hwdata[0]), .HSEL(hsel[0]), .busy(busy[0]),
    .done(done[0]), .mismatch(mm[0]), .rd_data(rd[0]));

  ahb_gpio_seq #(.STEPS(STEPS1), .INTERVAL(IVL1), .DIR_VAL(16'hFFFF)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start[1]), .abort(abort[1]),
    .HREADY(hready[1]), .HRDATA(hrdata[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HWDATA(hwdata[1]), .HSEL(hsel[1]), .busy(busy[1]),
    .done(done[1]), .mismatch(mm[1]), .rd_data(rd[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int ivl(input int i);
    return (i == 0) ? IVL0 : IVL1;
  endfunction

  // k-th transfer of a run: direction write, then alternating write/read
  function automatic void model(input int k, output bit w, output logic [31:0] a,
                                output logic [15:0] pat);
    int j;
    if (k == 0) begin
      w = 1'b1; a = 32'h4; pat = 16'hFFFF;
    end else begin
      j   = k - 1;
      w   = (j % 2 == 0);
      a   = 32'h0;
      pat = 16'h0001 << ((j / 2) % 16);
    end
  endfunction

  task automatic chk_zero(input int i, input string tag);
    chk($sformatf("%s u%0d haddr", tag, i), haddr[i], 32'h0);
    chk($sformatf("%s u%0d htrans", tag, i), 32'(htrans[i]), 32'h0);
    chk($sformatf("%s u%0d hwrite_hsel", tag, i), 32'({hwrite[i], hsel[i]}), 32'h0);
    chk($sformatf("%s u%0d hwdata", tag, i), hwdata[i], 32'h0);
    chk($sformatf("%s u%0d busy_done", tag, i), 32'({busy[i], done[i]}), 32'h0);
    chk($sformatf("%s u%0d mismatch", tag, i), 32'(mm[i]), 32'h0);
    chk($sformatf("%s u%0d rd_data", tag, i), 32'(rd[i]), 32'h0);
  endtask

  // bus monitor + slave, evaluated once per cycle on the falling edge
  task automatic mon(input int i);
    bit          ew;
    logic [31:0] ea;
    logic [15:0] pat;
    if (!HRESETn) begin
      in_data[i] = 0; in_addr[i] = 0; pend_rd[i] = 0; idle_cnt[i] = 0;
      return;
    end
    if (pend_rd[i]) begin
      chk($sformatf("u%0d rd_data", i), 32'(rd[i]), 32'(exp_rd[i]));
      chk($sformatf("u%0d mismatch", i), 32'(mm[i]), 32'(mm_model[i]));
      pend_rd[i] = 0;
    end
    if (done[i]) begin
      done_cnt[i]++;
      chk($sformatf("u%0d busy_at_done", i), 32'(busy[i]), 32'h0);
    end
    if (in_data[i]) begin
      chk($sformatf("u%0d data_no_addr", i), 32'({hsel[i], htrans[i]}), 32'h0);
      if (cur_write[i]) begin
        if (first[i]) cur_wd[i] = hwdata[i];
        else chk($sformatf("u%0d hwdata_hold", i), hwdata[i], cur_wd[i]);
      end
      first[i] = 0;
      if (hready[i]) begin
        model(xfer_cnt[i], ew, ea, pat);
        chk($sformatf("u%0d x%0d write", i, xfer_cnt[i]), 32'(cur_write[i]), 32'(ew));
        chk($sformatf("u%0d x%0d addr", i, xfer_cnt[i]), cur_addr[i], ea);
        if (cur_write[i]) begin
          chk($sformatf("u%0d x%0d wdata", i, xfer_cnt[i]), cur_wd[i], {16'h0, pat});
          if (cur_addr[i] == 32'h0) gpio[i] = cur_wd[i][15:0];
        end else begin
          pend_rd[i] = 1;
          exp_rd[i]  = gpio[i] & ~stuck[i];
          if (exp_rd[i] != pat) mm_model[i] = 1;
        end
        xfer_cnt[i]++;
        in_data[i]  = 0;
        idle_cnt[i] = 0;
      end
    end else if (htrans[i] == 2'b10) begin
      chk($sformatf("u%0d addr_hsel", i), 32'(hsel[i]), 32'h1);
      if (!in_addr[i]) begin
        a_addr[i] = haddr[i]; a_wr[i] = hwrite[i]; in_addr[i] = 1;
        if (!hwrite[i]) chk($sformatf("u%0d read_gap", i), 32'(idle_cnt[i]), 32'(ivl(i)));
      end else begin
        chk($sformatf("u%0d haddr_hold", i), haddr[i], a_addr[i]);
        chk($sformatf("u%0d hwrite_hold", i), 32'(hwrite[i]), 32'(a_wr[i]));
      end
      if (hready[i]) begin
        in_data[i] = 1; first[i] = 1; in_addr[i] = 0;
        cur_addr[i] = a_addr[i]; cur_write[i] = a_wr[i];
      end
    end else begin
      chk($sformatf("u%0d idle_hsel", i), 32'(hsel[i]), 32'h0);
      idle_cnt[i]++;
    end
  endtask

  // one bus cycle: monitor on the falling edge, new HREADY just after rising
  task automatic tick();
    @(negedge HCLK);
    mon(0);
    mon(1);
    @(posedge HCLK);
    #1;
    for (int i = 0; i < 2; i++)
      hready[i] = rnd[i] ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int i;
    int n;
    i = v.inst;
    stuck[i] = v.stuck; rnd[i] = v.rnd;
    xfer_cnt[i] = 0; done_cnt[i] = 0; mm_model[i] = 0;
    start[i] = 1'b1; abort[i] = v.abrt;
    tick();
    start[i] = 1'b0; abort[i] = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), 32'(busy[i]), 32'h1);
    chk($sformatf("v%0d mm_cleared", idx), 32'(mm[i]), 32'h0);
    n = 0;
    while (done_cnt[i] == 0 && n < 4000) begin tick(); n++; end
    repeat (3) tick();
    chk($sformatf("v%0d done_pulses", idx), 32'(done_cnt[i]), 32'h1);
    chk($sformatf("v%0d xfers", idx), 32'(xfer_cnt[i]), 32'(v.exp_xfers));
    chk($sformatf("v%0d mismatch", idx), 32'(mm[i]), 32'(v.exp_mm));
    chk($sformatf("v%0d rd_data", idx), 32'(rd[i]), 32'(v.exp_rd));
    chk($sformatf("v%0d busy_end", idx), 32'(busy[i]), 32'h0);
    rnd[i] = 0;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    HRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; abort[i] = 0; hready[i] = 1; stuck[i] = '0; rnd[i] = 0; gpio[i] = '0;
      xfer_cnt[i] = 0; done_cnt[i] = 0; idle_cnt[i] = 0; in_data[i] = 0; in_addr[i] = 0;
      first[i] = 0; cur_write[i] = 0; a_wr[i] = 0; pend_rd[i] = 0; mm_model[i] = 0;
      cur_addr[i] = '0; a_addr[i] = '0; cur_wd[i] = '0; exp_rd[i] = '0;
    end
    //         inst stuck     rnd  abrt xfers mm   rd
    tbl[0] = '{1, 16'h0000, 1'b0, 1'b0, 7,  1'b0, 16'h0004};
    tbl[1] = '{1, 16'h0002, 1'b0, 1'b0, 7,  1'b1, 16'h0004};
    tbl[2] = '{1, 16'h0000, 1'b1, 1'b0, 7,  1'b0, 16'h0004};
    tbl[3] = '{0, 16'h0000, 1'b1, 1'b0, 35, 1'b0, 16'h0001};
    tbl[4] = '{0, 16'h8000, 1'b0, 1'b0, 35, 1'b1, 16'h0001};
    tbl[5] = '{0, 16'h0001, 1'b1, 1'b0, 35, 1'b1, 16'h0000};
    tbl[6] = '{1, 16'h0000, 1'b0, 1'b1, 1,  1'b0, 16'h0004};

    // reset state
    #2 HRESETn = 1'b0;
    #3;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    @(posedge HCLK); #1;
    tick(); tick();
    HRESETn = 1'b1;
    repeat (4) tick();
    chk("no_done_after_reset u0", 32'(done_cnt[0]), 32'h0);
    chk("no_done_after_reset u1", 32'(done_cnt[1]), 32'h0);

    for (int v = 0; v < 7; v++) run_vec(v, tbl[v]);

    // abort while waiting before the read of step 1
    stuck[0] = '0; rnd[0] = 0; xfer_cnt[0] = 0; done_cnt[0] = 0; mm_model[0] = 0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (xfer_cnt[0] < 4 && n < 200) begin tick(); n++; end
    chk("abort reach_wait", 32'(xfer_cnt[0]), 32'h4);
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    chk("abort done", 32'(done[0]), 32'h1);
    chk("abort busy", 32'(busy[0]), 32'h0);
    chk("abort htrans", 32'({hsel[0], htrans[0]}), 32'h0);
    repeat (6) tick();
    chk("abort xfers", 32'(xfer_cnt[0]), 32'h4);
    chk("abort done_pulses", 32'(done_cnt[0]), 32'h1);
    chk("abort rd_data", 32'(rd[0]), 32'h0001);
    chk("abort mismatch", 32'(mm[0]), 32'h0);

    // asynchronous reset in the data phase of the first pattern write
    xfer_cnt[0] = 0; done_cnt[0] = 0; mm_model[0] = 0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (!(in_data[0] && cur_write[0] && cur_addr[0] == 32'h0) && n < 50) begin tick(); n++; end
    chk("midrst hwdata_before", hwdata[0], 32'h0000_0001);
    #2 HRESETn = 1'b0;
    #2;
    chk_zero(0, "midrst");
    tick(); tick();
    HRESETn = 1'b1;
    repeat (6) tick();
    chk("midrst no_done", 32'(done_cnt[0]), 32'h0);
    chk("midrst busy", 32'(busy[0]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_gpio_seq.md
Name: ahb_gpio_seq

Overview:
- Small AHB-Lite master that sequences the AHB GPIO slave without CPU involvement, for self-test and bring-up.
- On a start pulse it programs the GPIO direction register, then for STEPS iterations it:
  - writes a walking-one pattern to the data register,
  - waits INTERVAL cycles,
  - reads the data register back and compares it against the written pattern.
- Sits between the test-control logic and the GPIO slave's AHB port, multiplexed with the CPU bus by the system interconnect.

Parameters:
- STEPS, 16, number of write/wait/read iterations (1..65535).
- INTERVAL, 4, idle cycles between write data-phase completion and the read address phase (0..255).
- DIR_VAL, 16'hFFFF, value written to the direction register (address 0x04).

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; ignored while busy
- abort  in  1  single-cycle pulse; stop after the current transfer
- HREADY  in  1  slave HREADYOUT, looped back
- HRDATA  in  32  slave read data
- HADDR  out  32  transfer address
- HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ only
- HWRITE  out  1  write strobe
- HWDATA  out  32  write data (bits 31:16 always 0)
- HSEL  out  1  GPIO slave select
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when sequence ends (normal or aborted)
- mismatch  out  1  sticky; cleared by next accepted start
- rd_data  out  16  last read-back value

Behaviour:
- Reset (async, HRESETn low): state IDLE. All outputs 0: HTRANS=2'b00, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, busy=0, done=0, mismatch=0, rd_data=0. Step and interval counters 0.
- AHB-Lite pipelining:
  - Address phase: HSEL=1, HTRANS=NONSEQ, HADDR, HWRITE.
  - The address phase is held until a rising edge with HREADY=1.
  - The next cycle is the data phase; HWDATA is valid for the whole data phase.
  - The data phase ends on the first edge with HREADY=1. Read data is sampled on that edge.
  - No new address phase overlaps a data phase; transfers are strictly single, non-pipelined. Outside address phases, HTRANS=IDLE and HSEL=0.
- States and transitions:
  - IDLE: start accepted -> DIR_A. busy=1 from the next cycle; mismatch cleared; step=0.
  - DIR_A: address 0x04, write. HREADY -> DIR_D.
  - DIR_D: HWDATA={16'h0,DIR_VAL}. HREADY -> WR_A.
  - WR_A: address 0x00, write. HREADY -> WR_D.
  - WR_D: HWDATA={16'h0, 16'h0001 << step[3:0]}. HREADY -> WAIT, interval counter loaded with INTERVAL. If INTERVAL=0, go directly to RD_A.
  - WAIT: decrement each cycle; at 1 -> RD_A. Exactly INTERVAL idle bus cycles.
  - RD_A: address 0x00, read. HREADY -> RD_D.
  - RD_D: on HREADY:
    - rd_data <= HRDATA[15:0].
    - If HRDATA[15:0] != written pattern, mismatch <= 1.
    - step++. If step == STEPS -> FIN, else -> WR_A.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Pattern wraps every 16 steps: step 16 reuses 16'h0001.
- abort:
  - Sampled in any non-IDLE state and latched as pending.
  - An address phase already presented is completed through its data phase.
  - After that data phase completes, go to FIN instead of the next transfer. In WAIT, go to FIN immediately.
  - abort in IDLE is ignored.
  - start and abort in the same cycle in IDLE: start wins, then abort is pending -> DIR_A completes, then FIN.
- Wait states: any number of HREADY-low cycles in a data phase holds the state, HWDATA, and (for the address phase) HADDR/HTRANS stable.
- Reset mid-operation: immediate return to reset values. No completion and no done pulse.
- done is not asserted after reset alone.

Test Plan:
- Reset, then start with STEPS=3, INTERVAL=2, HREADY=1, GPIOOUT looped to GPIOIN:
  - Writes 0x04<-0xFFFF, then 0x00<-0x0001/0x0002/0x0004.
  - Exactly 2 idle cycles before each read.
  - rd_data=0x0004, mismatch=0, done pulse 1 cycle, busy low after.
- Same run with GPIOIN bit 1 stuck at 0 -> mismatch=1 after the second read and stays 1. A subsequent start clears it.
- HREADY held low for 3 cycles in the WR_D of step 0 -> HWDATA=0x0001 stable for all 4 data-phase cycles. No new address phase until HREADY high.
- abort asserted during WAIT of step 1 (STEPS=16) -> no read issued, done pulse next cycle, HTRANS=IDLE, busy=0.
- STEPS=17, INTERVAL=0 -> step 16 writes 0x0001 (wrap). Read address phase immediately follows the write data phase.
- HRESETn low mid WR_D -> outputs 0 asynchronously, before the next HCLK edge. No done pulse.
